mcycle_arbiter: RTL and testbench

MCYCLE_ARBITER -- requirements
Module: mcycle_arbiter

---
 rtl/mcycle_arbiter_if.sv | 37 +++
 rtl/mcycle_arbiter.sv | 119 +++++++++++
 tb/tb_mcycle_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mcycle_arbiter_if.sv
// Requester, shared-unit and response signals of the multi-cycle arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface mcycle_arbiter_if #(
    parameter int width = 32
);
    logic [1:0]       Req;
    logic [1:0]       Op;
    logic [width-1:0] A0;
    logic [width-1:0] B0;
    logic [width-1:0] A1;
    logic [width-1:0] B1;
    logic [1:0]       Ack;
    logic [1:0]       RespValid;
    logic             RespErr;
    logic [width-1:0] RespLo;
    logic [width-1:0] RespHi;
    logic             MStart;
    logic             MOp;
    logic [width-1:0] MOperand1;
    logic [width-1:0] MOperand2;
    logic             MBusy;
    logic [width-1:0] MResult1;
    logic [width-1:0] MResult2;
    logic             Busy;

    modport slave (
        input  Req, Op, A0, B0, A1, B1, MBusy, MResult1, MResult2,
        output Ack, RespValid, RespErr, RespLo, RespHi,
        output MStart, MOp, MOperand1, MOperand2, Busy
    );

    modport master (
        output Req, Op, A0, B0, A1, B1, MBusy, MResult1, MResult2,
        input  Ack, RespValid, RespErr, RespLo, RespHi,
        input  MStart, MOp, MOperand1, MOperand2, Busy
    );
endinterface

// File: rtl/mcycle_arbiter.sv
// Two-requester round-robin arbiter in front of one shared multi-cycle unit.
// A WAIT-state timeout aborts an operation that never completes.
module mcycle_arbiter #(
    parameter int width   = 32,
    parameter int TIMEOUT = 80
) (
    input logic              CLK,
    input logic              Reset,
    mcycle_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             mop_q, mop_d;
    logic [width-1:0] opa_q, opa_d;
    logic [width-1:0] opb_q, opb_d;
    logic [width-1:0] lo_q, lo_d;
    logic [width-1:0] hi_q, hi_d;

    logic          pick;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    gmask;

    // On a tie the requester not served last wins
    assign pick    = (&bus.Req) ? ~last_q : bus.Req[1];
    assign cnt_inc = cnt_q + CW'(1);
    assign gmask   = {grant_q, ~grant_q};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mop_d   = mop_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.Req) begin
                    grant_d = pick;
                    mop_d   = pick ? bus.Op[1] : bus.Op[0];
                    opa_d   = pick ? bus.A1 : bus.A0;
                    opb_d   = pick ? bus.B1 : bus.B0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // Completion takes priority over a coincident timeout
                if (!bus.MBusy) begin
                    lo_d    = bus.MResult1;
                    hi_d    = bus.MResult2;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    lo_d    = '0;
                    hi_d    = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            mop_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mop_q   <= mop_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign bus.Ack       = (state_q == ISSUE) ? gmask : 2'b00;
    assign bus.MStart    = (state_q == ISSUE);
    assign bus.RespValid = (state_q == RESP) ? gmask : 2'b00;
    assign bus.RespErr   = (state_q == RESP) & err_q;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.MOp       = mop_q;
    assign bus.MOperand1 = opa_q;
    assign bus.MOperand2 = opb_q;
    assign bus.RespLo    = lo_q;
    assign bus.RespHi    = hi_q;
endmodule

// File: tb/tb_mcycle_arbiter.sv
// Directed bench for mcycle_arbiter.
// Covers reset, single and round-robin grants, timeout, mid-transaction reset and operand hold.
module tb_mcycle_arbiter;
    localparam int W = 32;

    logic CLK;
    logic Reset;
    int   checks;
    int   failures;
    int   pulses;

    mcycle_arbiter_if #(.width(W)) bus ();

    mcycle_arbiter #(.width(W), .TIMEOUT(80)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        bus.Req  = 2'b00;
        bus.Op   = 2'b00;
        bus.A0   = '0;
        bus.B0   = '0;
        bus.A1   = '0;
        bus.B1   = '0;
        bus.MBusy    = 1'b0;
        bus.MResult1 = '0;
        bus.MResult2 = '0;
        tick;
        tick;
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_ack", 64'(bus.Ack), 64'd0);
        chk("rst_mstart", 64'(bus.MStart), 64'd0);
        chk("rst_lo", 64'(bus.RespLo), 64'd0);
        Reset = 1'b0;

        // Single multiply from requester 0, unit busy for 33 WAIT cycles
        bus.Req = 2'b01;
        bus.Op  = 2'b00;
        bus.A0  = 6;
        bus.B0  = 7;
        bus.MBusy = 1'b1;
        tick;
        chk("t1_ack", 64'(bus.Ack), 64'b01);
        chk("t1_mstart", 64'(bus.MStart), 64'd1);
        chk("t1_mop", 64'(bus.MOp), 64'd0);
        chk("t1_opa", 64'(bus.MOperand1), 64'd6);
        chk("t1_opb", 64'(bus.MOperand2), 64'd7);
        chk("t1_busy", 64'(bus.Busy), 64'd1);
        bus.Req = 2'b00;
        tick;
        pulses = 0;
        for (int i = 0; i < 33; i++) begin
            pulses += int'(|bus.Ack) + int'(bus.MStart) + int'(|bus.RespValid);
            if (i == 3) begin
                bus.A0  = 99;
                bus.B0  = 88;
                bus.Req = 2'b10;
            end
            if (i == 4) bus.Req = 2'b00;
            tick;
        end
        chk("t1_wait_pulses", 64'(pulses), 64'd0);
        chk("t1_hold_opa", 64'(bus.MOperand1), 64'd6);
        chk("t1_hold_opb", 64'(bus.MOperand2), 64'd7);
        bus.MBusy    = 1'b0;
        bus.MResult1 = 42;
        bus.MResult2 = 5;
        tick;
        chk("t1_rv", 64'(bus.RespValid), 64'b01);
        chk("t1_lo", 64'(bus.RespLo), 64'd42);
        chk("t1_hi", 64'(bus.RespHi), 64'd5);
        chk("t1_err", 64'(bus.RespErr), 64'd0);
        bus.MResult1 = 500;
        tick;
        chk("t1_rv_off", 64'(bus.RespValid), 64'd0);
        chk("t1_idle", 64'(bus.Busy), 64'd0);
        chk("t1_lo_hold", 64'(bus.RespLo), 64'd42);
        tick;
        chk("t1_no_req1", 64'(bus.Busy), 64'd0);
        chk("t1_no_ack", 64'(bus.Ack), 64'd0);

        // Both requesting from reset: grants alternate 0,1,0,1
        Reset   = 1'b1;
        bus.Req = 2'b11;
        bus.A0  = 1;
        bus.A1  = 2;
        bus.MBusy = 1'b0;
        tick;
        Reset = 1'b0;
        tick;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] oh;
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_ack", 64'(bus.Ack), 64'(oh));
            chk("rr_opa", 64'(bus.MOperand1), (k % 2 == 0) ? 64'd1 : 64'd2);
            tick;
            chk("rr_wait_ack", 64'(bus.Ack), 64'd0);
            tick;
            chk("rr_rv", 64'(bus.RespValid), 64'(oh));
            tick;
            chk("rr_idle", 64'(bus.Busy), 64'd0);
            if (k == 3) bus.Req = 2'b00;
            tick;
        end
        chk("rr_done", 64'(bus.Busy), 64'd0);

        // Unit stuck busy: abort after 80 WAIT cycles
        bus.Req = 2'b01;
        bus.Op  = 2'b00;
        bus.MBusy    = 1'b1;
        bus.MResult1 = 1234;
        bus.MResult2 = 5678;
        tick;
        bus.Req = 2'b00;
        tick;
        repeat (79) tick;
        chk("to_not_yet", 64'(bus.RespValid), 64'd0);
        chk("to_busy", 64'(bus.Busy), 64'd1);
        tick;
        chk("to_rv", 64'(bus.RespValid), 64'b01);
        chk("to_err", 64'(bus.RespErr), 64'd1);
        chk("to_lo", 64'(bus.RespLo), 64'd0);
        chk("to_hi", 64'(bus.RespHi), 64'd0);
        tick;
        chk("to_err_off", 64'(bus.RespErr), 64'd0);

        // Next request after a timeout: requester 1 divide
        bus.Req = 2'b10;
        bus.Op  = 2'b10;
        bus.A1  = 11;
        bus.B1  = 13;
        bus.MBusy    = 1'b0;
        bus.MResult1 = 77;
        bus.MResult2 = 3;
        tick;
        chk("nx_ack", 64'(bus.Ack), 64'b10);
        chk("nx_mop", 64'(bus.MOp), 64'd1);
        chk("nx_opa", 64'(bus.MOperand1), 64'd11);
        chk("nx_opb", 64'(bus.MOperand2), 64'd13);
        bus.Req = 2'b00;
        tick;
        tick;
        chk("nx_rv", 64'(bus.RespValid), 64'b10);
        chk("nx_err", 64'(bus.RespErr), 64'd0);
        chk("nx_lo", 64'(bus.RespLo), 64'd77);
        tick;

        // Reset in the middle of WAIT
        bus.Req = 2'b01;
        bus.Op  = 2'b01;
        bus.A0  = 5;
        bus.MBusy = 1'b1;
        tick;
        bus.Req = 2'b00;
        tick;
        tick;
        Reset = 1'b1;
        #1;
        chk("mr_ack", 64'(bus.Ack), 64'd0);
        chk("mr_rv", 64'(bus.RespValid), 64'd0);
        chk("mr_err", 64'(bus.RespErr), 64'd0);
        chk("mr_mstart", 64'(bus.MStart), 64'd0);
        chk("mr_mop", 64'(bus.MOp), 64'd0);
        chk("mr_opa", 64'(bus.MOperand1), 64'd0);
        chk("mr_opb", 64'(bus.MOperand2), 64'd0);
        chk("mr_lo", 64'(bus.RespLo), 64'd0);
        chk("mr_hi", 64'(bus.RespHi), 64'd0);
        chk("mr_busy", 64'(bus.Busy), 64'd0);
        pulses = 0;
        tick;
        pulses += int'(|bus.RespValid);
        tick;
        pulses += int'(|bus.RespValid);
        chk("mr_no_rv", 64'(pulses), 64'd0);
        Reset = 1'b0;
        bus.MBusy = 1'b0;
        bus.Req = 2'b10;
        bus.A1  = 21;
        tick;
        chk("mr_ack1", 64'(bus.Ack), 64'b10);
        chk("mr_opa1", 64'(bus.MOperand1), 64'd21);
        bus.Req = 2'b00;
        tick;
        tick;
        chk("mr_rv1", 64'(bus.RespValid), 64'b10);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
